// File: rtl/regbank_dump_ctrl.sv
// ---------------------------------------------------------------------------
// regbank_dump_ctrl
// Debug-unit controller that dumps the ID-stage register bank over a byte
// stream. A start request walks registers 0..NUM_REGS-1 in order. It reads each
// one through bank read port 1 and emits the word MSB byte first on a
// valid/ready interface towards the UART transmitter. While idle, the pipeline
// rs/rt addresses pass straight through to the bank.
//
// Ports
//   i_clk            clock, all state on posedge
//   i_reset          asynchronous, active-low reset
//   i_start          dump request, honoured only while idle
//   i_pipe_rs_addr   pipeline rs address (drives read port 1 when idle)
//   i_pipe_rt_addr   pipeline rt address (always drives read port 2)
//   o_rb_read_reg1   bank read port 1 address (muxed)
//   o_rb_read_reg2   bank read port 2 address
//   i_rb_data_read1  bank read data 1 (combinational read)
//   o_tx_data        byte offered to the transmitter
//   o_tx_valid       o_tx_data is valid
//   i_tx_ready       transmitter accepts the byte this cycle
//   o_busy           dump in progress, read port 1 owned by this block
//   o_done           one-cycle pulse when the dump completes
// ---------------------------------------------------------------------------
module regbank_dump_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_pipe_rs_addr,
  input  logic [ADDR_WIDTH-1:0] i_pipe_rt_addr,
  output logic [ADDR_WIDTH-1:0] o_rb_read_reg1,
  output logic [ADDR_WIDTH-1:0] o_rb_read_reg2,
  input  logic [DATA_WIDTH-1:0] i_rb_data_read1,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]        byte_cnt, byte_cnt_nxt;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      idx       <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    byte_cnt_nxt = byte_cnt;
    shift_nxt    = shift_reg;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      LOAD: begin
        // Read port 1 already points at idx, so the bank data is valid now.
        shift_nxt    = i_rb_data_read1;
        byte_cnt_nxt = '0;
        state_nxt    = SEND;
      end
      SEND: begin
        // Valid is always high in SEND, so ready alone marks a handshake.
        if (i_tx_ready) begin
          if (byte_cnt != LAST_BYTE) begin
            shift_nxt    = shift_reg << 8;
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
          end else if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ADDR_WIDTH'(1);
            state_nxt = LOAD;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode from the state register alone, so an asynchronous reset
  // silences the stream and the busy/done flags in the same instant.
  always_comb begin
    o_busy         = (state != IDLE);
    o_done         = (state == DONE);
    o_tx_valid     = (state == SEND);
    o_tx_data      = (state == SEND) ? shift_reg[DATA_WIDTH-1 -: 8] : 8'h00;
    o_rb_read_reg1 = o_busy ? idx : i_pipe_rs_addr;
    o_rb_read_reg2 = i_pipe_rt_addr;
  end

endmodule
